// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, default bubble instruction and fetch FSM states
package fetch_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    typedef enum logic {BOOT, RUN} state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble wins over hold and keeps the PC fields
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            bubble,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [ILEN-1:0] instr,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [ILEN-1:0] id_instr
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            id_instr    <= NOP_INSTR;
        end else if (bubble) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (!hold) begin
            id_valid    <= 1'b1;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            id_instr    <= instr;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, BOOT/RUN FSM and fetch counter
// feeding the IF/ID register; priority in RUN is redirect > flush > stall > normal.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [ILEN-1:0] imem_instr_i,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc_plus4_o,
    output logic [ILEN-1:0] id_instr_o,
    output logic [31:0]     fetch_count_o
);
    state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic run, bubble, hold, load;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= BOOT;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d  = RUN;
        run      = state_q == RUN;
        bubble   = !run || redirect_i || flush_i;
        hold     = stall_i;
        load     = !bubble && !stall_i;
        pc_plus4 = pc_q + 64'd4;
        pc_d     = !run ? pc_q : redirect_i ? (redirect_pc_i & ~64'd3) : stall_i ? pc_q : pc_plus4;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            fetch_count_o <= '0;
        end else begin
            pc_q <= pc_d;
            if (load && fetch_count_o != 32'hFFFF_FFFF) fetch_count_o <= fetch_count_o + 32'd1;
        end
    end
    assign imem_addr_o = {2'b00, pc_q[XLEN-1:2]};
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .bubble      (bubble),
        .pc          (pc_q),
        .pc_plus4    (pc_plus4),
        .instr       (imem_instr_i),
        .id_valid    (id_valid_o),
        .id_pc       (id_pc_o),
        .id_pc_plus4 (id_pc_plus4_o),
        .id_instr    (id_instr_o)
    );
endmodule
